frame_extract: RTL and testbench

//  Consumes the word-aligned 16-bit stream from the lane-lock aligner (valid/dataout) and

---
 rtl/frame_extract_pkg.sv | 39 +++
 rtl/frame_extract_sync_fifo.sv | 58 +++++
 rtl/frame_extract.sv | 218 +++++++++++++++++++++
 tb/tb_frame_extract.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_extract_pkg.sv
// rtl/frame_extract_pkg.sv - shared constants, FSM states, FIFO word layout and CRC step for frame_extract
package frame_extract_pkg;

  localparam logic [15:0] SYNC_PATTERN = 16'h817E;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 12;
  localparam int LEN_MSB  = 11;
  localparam int LEN_LSB  = 0;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    HUNT,
    SYNC_SEEN,
    PAYLOAD,
    CRC,
    DROP
  } state_t;

  typedef struct packed {
    logic [3:0]  ftype;
    logic        err;
    logic        eof;
    logic        sof;
    logic [15:0] data;
  } fifo_word_t;

  // CRC-16-CCITT over one 16-bit word, MSB first
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_extract_sync_fifo.sv
// rtl/frame_extract_sync_fifo.sv - show-ahead synchronous FIFO with registered head and occupancy count
module frame_extract_sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      mem_count;
  logic             pop;
  logic             load;

  assign pop  = rd_en & rd_valid;
  // Refill the head register from memory whenever it is empty or being consumed
  assign load = (mem_count != '0) && (!rd_valid || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (load) begin
        rptr     <= rptr + AW'(1);
        rd_data  <= mem[rptr];
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      case ({wr_en, load})
        2'b10:   mem_count <= mem_count + (AW+1)'(1);
        2'b01:   mem_count <= mem_count - (AW+1)'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

  assign count = mem_count + {{AW{1'b0}}, rd_valid};

endmodule

// File: rtl/frame_extract.sv
// rtl/frame_extract.sv - length-delimited frame recovery into a ready/valid FIFO
// CRC_CHECK_EN adds a trailing CRC-16 word per frame, checked via a one-word hold register.
module frame_extract
  import frame_extract_pkg::*;
#(
  parameter int MAX_LEN    = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int FIFO_AW    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [3:0]  out_type,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count,
  output logic        len_err
);

`ifdef CRC_CHECK_EN
  localparam logic [11:0] CRC_EXTRA = 12'd1;
`else
  localparam logic [11:0] CRC_EXTRA = 12'd0;
`endif

  state_t          state;
  state_t          state_nx;
  logic [11:0]     remaining;
  logic [3:0]      ftype;
  logic            first;
  logic [FIFO_AW:0] occupancy;
  logic [12:0]     free;
  logic [11:0]     hdr_len;
  logic            hdr_bad;
  logic            last_word;
  logic            wr_en;
  logic            wr_en_nx;
  fifo_word_t      wr_word;
  fifo_word_t      wr_word_nx;
  logic            load_hdr;
  logic            drop_start;
  logic            dec_rem;
  logic            frame_inc;
  logic            drop_inc;
  logic            len_err_nx;
  logic [22:0]     head_bits;
  fifo_word_t      head;

`ifdef CRC_CHECK_EN
  logic [15:0] crc;
  logic [15:0] hold_data;
  logic        hold_sof;
  logic        hold_valid;
  logic        crc_bad;
  assign crc_bad = (crc != in_data);
`endif

  assign hdr_len   = in_data[LEN_MSB:LEN_LSB];
  assign hdr_bad   = (hdr_len == 12'd0) || (hdr_len > 12'(MAX_LEN));
  assign free      = 13'(FIFO_DEPTH) - 13'(occupancy);
  assign last_word = (remaining == 12'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    wr_en_nx   = 1'b0;
    wr_word_nx = '0;
    load_hdr   = 1'b0;
    drop_start = 1'b0;
    dec_rem    = 1'b0;
    frame_inc  = 1'b0;
    drop_inc   = 1'b0;
    len_err_nx = 1'b0;
    case (state)
      HUNT: begin
        if (in_valid && in_data == SYNC_PATTERN) state_nx = SYNC_SEEN;
      end
      SYNC_SEEN: begin
        if (in_valid && in_data != SYNC_PATTERN) begin
          if (hdr_bad) begin
            len_err_nx = 1'b1;
            drop_inc   = 1'b1;
            state_nx   = HUNT;
          end else if (free < 13'(hdr_len)) begin
            drop_inc   = 1'b1;
            drop_start = 1'b1;
            state_nx   = DROP;
          end else begin
            load_hdr = 1'b1;
            state_nx = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          dec_rem = 1'b1;
`ifdef CRC_CHECK_EN
          // Each word retires the previously held one; the last stays held for the CRC verdict
          if (hold_valid) begin
            wr_en_nx   = 1'b1;
            wr_word_nx = '{ftype, 1'b0, 1'b0, hold_sof, hold_data};
          end
          if (last_word) state_nx = CRC;
`else
          wr_en_nx   = 1'b1;
          wr_word_nx = '{ftype, 1'b0, last_word, first, in_data};
          if (last_word) begin
            frame_inc = 1'b1;
            state_nx  = HUNT;
          end
`endif
        end
      end
      CRC: begin
`ifdef CRC_CHECK_EN
        if (in_valid) begin
          wr_en_nx   = 1'b1;
          wr_word_nx = '{ftype, crc_bad, 1'b1, hold_sof, hold_data};
          frame_inc  = !crc_bad;
          state_nx   = HUNT;
        end
`else
        state_nx = HUNT;
`endif
      end
      DROP: begin
        if (in_valid) begin
          dec_rem = 1'b1;
          if (last_word) state_nx = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining   <= '0;
      ftype       <= '0;
      first       <= 1'b0;
      wr_en       <= 1'b0;
      wr_word     <= '0;
      frame_count <= '0;
      drop_count  <= '0;
      len_err     <= 1'b0;
    end else begin
      if (load_hdr) begin
        remaining <= hdr_len;
        ftype     <= in_data[TYPE_MSB:TYPE_LSB];
      end else if (drop_start) begin
        remaining <= hdr_len + CRC_EXTRA;
      end else if (dec_rem) begin
        remaining <= remaining - 12'd1;
      end
      if (load_hdr)                          first <= 1'b1;
      else if (state == PAYLOAD && in_valid) first <= 1'b0;
      wr_en   <= wr_en_nx;
      wr_word <= wr_word_nx;
      if (frame_inc) frame_count <= frame_count + 16'd1;
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      len_err <= len_err_nx;
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc        <= CRC_INIT;
      hold_data  <= '0;
      hold_sof   <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (load_hdr)                          crc <= crc16_word(CRC_INIT, in_data);
      else if (state == PAYLOAD && in_valid) crc <= crc16_word(crc, in_data);
      if (state == PAYLOAD && in_valid) begin
        hold_data  <= in_data;
        hold_sof   <= first;
        hold_valid <= 1'b1;
      end else if (state == CRC && in_valid) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

  frame_extract_sync_fifo #(
    .WIDTH ($bits(fifo_word_t)),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) sync_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_word),
    .rd_en    (out_ready),
    .rd_data  (head_bits),
    .rd_valid (out_valid),
    .count    (occupancy)
  );

  assign head     = fifo_word_t'(head_bits);
  assign out_data = head.data;
  assign out_sof  = head.sof;
  assign out_eof  = head.eof;
  assign out_err  = head.err;
  assign out_type = head.ftype;

endmodule

// File: tb/tb_frame_extract.sv
// tb/tb_frame_extract.sv - scoreboard bench for frame_extract (directed frames, CRC_CHECK_EN aware)
module tb_frame_extract;

  localparam logic [15:0] SYNC = 16'h817E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [3:0]  out_type;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic        len_err;

  logic [22:0] exp_q [$];
  logic [15:0] pay_q [$];
  int passed = 0;
  int total = 0;
  int len_err_seen = 0;
  int exp_frames = 0;
  int exp_drops = 0;

  frame_extract dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_err     (out_err),
    .out_type    (out_type),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 16; i++) begin
      fb = r[15] ^ d[15-i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Monitor: every accepted output word must match the head of the expected queue
  always @(negedge clk) begin
    logic [22:0] got;
    logic [22:0] want;
    if (rst_n && len_err) len_err_seen++;
    if (rst_n && out_valid && out_ready) begin
      got = {out_type, out_err, out_eof, out_sof, out_data};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word got %h required none", got);
      end else begin
        want = exp_q.pop_front();
        if (got === want) passed++;
        else $display("FAIL out_word got %h required %h", got, want);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got %0h required %0h", name, got, want);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'h0;
  endtask

  task automatic send_frame(input logic [3:0] t, input bit accept, input bit bad_crc, input bit gaps);
    logic [15:0] hdr;
    logic [15:0] c;
    int n;
    n   = pay_q.size();
    hdr = {t, 12'(n)};
    c   = crc_step(16'hFFFF, hdr);
    send(SYNC);
    send(hdr);
    for (int i = 0; i < n; i++) begin
      send(pay_q[i]);
      if (gaps) idle(1);
      c = crc_step(c, pay_q[i]);
      if (accept) exp_q.push_back({t, bad_crc && (i == n-1), i == n-1, i == 0, pay_q[i]});
    end
`ifdef CRC_CHECK_EN
    send(bad_crc ? (c ^ 16'h0100) : c);
`endif
    if (accept && !bad_crc) exp_frames++;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
    idle(3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    check("reset_outputs", {out_valid, out_data, out_sof, out_eof, out_err, out_type, len_err},
          32'h0);
    check("reset_counters", {frame_count, drop_count}, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // 1: repeated SYNC then a 4-word frame
    send(SYNC);
    send(SYNC);
    pay_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_frame(4'd3, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("frame_count_t1", 32'(frame_count), 32'd1);

    // 2: SYNC pattern inside payload, idle gaps, then another frame proves return to HUNT
    pay_q = '{16'hAAAA, 16'h817E, 16'hBBBB};
    send_frame(4'd5, 1'b1, 1'b0, 1'b1);
    pay_q = '{16'h0042};
    send_frame(4'd1, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("frame_count_t2", 32'(frame_count), 32'd3);

    // 3: illegal lengths 0 and MAX_LEN+1
    send(SYNC);
    send(16'h1000);
    send(SYNC);
    send(16'h1101);
    idle(4);
    exp_drops += 2;
    check("drop_count_t3", 32'(drop_count), 32'(exp_drops));
    check("len_err_pulses", 32'(len_err_seen), 32'd2);

    // 4: fill the FIFO with two max frames, third is dropped, fourth fits after draining
    out_ready = 1'b0;
    pay_q = {};
    for (int i = 0; i < 256; i++) pay_q.push_back(16'(i) ^ 16'h5A00);
    send_frame(4'd2, 1'b1, 1'b0, 1'b0);
    pay_q = {};
    for (int i = 0; i < 256; i++) pay_q.push_back(16'(i) ^ 16'hC300);
    send_frame(4'd4, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("full_head_valid", 32'(out_valid), 32'd1);
    pay_q = '{16'hDEAD};
    send_frame(4'd6, 1'b0, 1'b0, 1'b0);
    idle(3);
    exp_drops++;
    check("drop_count_t4", 32'(drop_count), 32'(exp_drops));
    out_ready = 1'b1;
    wait_drain();
    pay_q = '{16'hC0DE, 16'h0001};
    send_frame(4'd7, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("frame_count_t4", 32'(frame_count), 32'(exp_frames));
    check("drop_count_t4b", 32'(drop_count), 32'(exp_drops));

`ifdef CRC_CHECK_EN
    // 5: corrupted CRC flags err on eof and does not count
    pay_q = '{16'h1234, 16'h5678};
    send_frame(4'd9, 1'b1, 1'b1, 1'b0);
    wait_drain();
    check("frame_count_badcrc", 32'(frame_count), 32'(exp_frames));
    pay_q = '{16'h9ABC};
    send_frame(4'd9, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("frame_count_goodcrc", 32'(frame_count), 32'(exp_frames));
`endif

    // 6: reset in the middle of a payload, then a clean frame
    out_ready = 1'b0;
    send(SYNC);
    send(16'h2004);
    send(16'hBAD0);
    send(16'hBAD1);
    rst_n = 1'b0;
    idle(2);
    check("midreset_outputs", {out_valid, out_data, out_sof, out_eof, out_err, out_type, len_err},
          32'h0);
    check("midreset_counters", {frame_count, drop_count}, 32'h0);
    rst_n = 1'b1;
    exp_frames = 0;
    exp_drops = 0;
    out_ready = 1'b1;
    idle(2);
    pay_q = '{16'h0600, 16'h0601, 16'h0602};
    send_frame(4'd8, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("frame_count_t6", 32'(frame_count), 32'(exp_frames));
    check("drop_count_t6", 32'(drop_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
